// File: rtl/bash_pkg.sv
// Shared types and constants for the bash command back end.
// Holds FSM states, response kinds and the fixed ASCII strings.
package bash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_SAMPLE,
    RX_WAIT,
    PARSE,
    TX,
    SOLVE,
    WAIT_ACK
  } state_t;

  typedef enum logic [1:0] {
    RK_NONE,
    RK_ECHO,
    RK_HELLO,
    RK_NF
  } resp_kind_t;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] NUL   = 8'h00;

  localparam int ECHO_LEN  = 4;
  localparam int HELLO_LEN = 5;
  localparam int GREET_LEN = 12;
  localparam int NF_LEN    = 19;

  localparam logic [8*ECHO_LEN-1:0]  ECHO_STR  = "echo";
  localparam logic [8*HELLO_LEN-1:0] HELLO_STR = "hello";
  localparam logic [8*GREET_LEN-1:0] GREET_STR = "Hello, FPGA!";
  localparam logic [8*NF_LEN-1:0]    NF_STR    = ": command not found";

  localparam logic STR_GREET = 1'b0;
  localparam logic STR_NF    = 1'b1;

endpackage

// File: rtl/bash_resp_rom.sv
// Constant response strings, indexed byte by byte.
// Any index past the end of a string reads as NUL.
module bash_resp_rom
  import bash_pkg::*;
(
  input  logic       id,
  input  logic [7:0] idx,
  output logic [7:0] ch
);

  // byte lookup for the selected string
  always_comb begin
    ch = NUL;
    if (id == STR_GREET) begin
      if (idx < 8'(GREET_LEN))
        ch = GREET_STR[8*(GREET_LEN-1-int'(idx)) +: 8];
    end else begin
      if (idx < 8'(NF_LEN))
        ch = NF_STR[8*(NF_LEN-1-int'(idx)) +: 8];
    end
  end

endmodule

// File: rtl/bash_cmd_dispatcher.sv
// Receives a console line, decodes the first word and streams
// one response line back, then signals command completion.
module bash_cmd_dispatcher
  import bash_pkg::*;
#(
  parameter int MAX_LEN  = 128,
  parameter int MAX_WORD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_ready,
  input  logic [12:0] line_len,
  input  logic [7:0]  line_char,
  output logic        line_next,
  output logic        resp_ready,
  output logic [7:0]  resp_char,
  input  logic        resp_next,
  output logic        solved,
  input  logic        solved_ack,
  output logic        busy
);

  localparam int AW = $clog2(MAX_LEN);

  state_t     state, state_nx;
  resp_kind_t kind_r, kind_c, sel_kind;

  logic [12:0]   len, rx_cnt, len_in, rlen;
  logic [7:0]    line_buf [MAX_LEN];
  logic [7:0]    wlen_r, wlen_c, sel_wlen;
  logic [7:0]    tot_r, tot_c, tx_idx, sel_idx;
  logic [7:0]    ch_c, rom_idx, rom_ch;
  logic [AW-1:0] ebi;
  logic          rom_id, is_echo, is_hello, stop;

  assign len_in = (line_len > 13'(MAX_LEN)) ? 13'(MAX_LEN) : line_len;
  assign rlen   = (len > 13'd5) ? len - 13'd5 : 13'd0;

  bash_resp_rom u_rom (
    .id  (rom_id),
    .idx (rom_idx),
    .ch  (rom_ch)
  );

  // decode the first word of the received line
  always_comb begin
    is_echo = (len >= 13'(ECHO_LEN));
    for (int i = 0; i < ECHO_LEN; i++)
      if (line_buf[i] != ECHO_STR[8*(ECHO_LEN-1-i) +: 8])
        is_echo = 1'b0;
    is_echo = is_echo &&
              (len == 13'(ECHO_LEN) || line_buf[ECHO_LEN] == SPACE);
    is_hello = (len == 13'(HELLO_LEN));
    for (int i = 0; i < HELLO_LEN; i++)
      if (line_buf[i] != HELLO_STR[8*(HELLO_LEN-1-i) +: 8])
        is_hello = 1'b0;
    wlen_c = 8'd0;
    stop   = 1'b0;
    for (int i = 0; i < MAX_WORD; i++) begin
      if (!stop && 13'(i) < len && line_buf[i] != SPACE)
        wlen_c = 8'(i + 1);
      else
        stop = 1'b1;
    end
    if (len == 13'd0)  kind_c = RK_NONE;
    else if (is_echo)  kind_c = RK_ECHO;
    else if (is_hello) kind_c = RK_HELLO;
    else               kind_c = RK_NF;
    case (kind_c)
      RK_ECHO:  tot_c = rlen[7:0];
      RK_HELLO: tot_c = 8'(GREET_LEN);
      RK_NF:    tot_c = wlen_c + 8'(NF_LEN);
      default:  tot_c = 8'd0;
    endcase
  end

  // pick the response byte to load next into resp_char
  always_comb begin
    sel_kind = (state == PARSE) ? kind_c : kind_r;
    sel_wlen = (state == PARSE) ? wlen_c : wlen_r;
    sel_idx  = (state == PARSE) ? 8'd0 : tx_idx + 8'd1;
    ebi      = AW'(sel_idx) + AW'(5);
    rom_id   = STR_GREET;
    rom_idx  = sel_idx;
    ch_c     = NUL;
    case (sel_kind)
      RK_ECHO:
        if (13'(sel_idx) < rlen) ch_c = line_buf[ebi];
      RK_HELLO:
        ch_c = rom_ch;
      RK_NF:
        if (sel_idx < sel_wlen) begin
          ch_c = line_buf[AW'(sel_idx)];
        end else begin
          rom_id  = STR_NF;
          rom_idx = sel_idx - sel_wlen;
          ch_c    = rom_ch;
        end
      default:
        ch_c = NUL;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:
        if (line_ready)
          state_nx = (len_in == 13'd0) ? PARSE : RX_SAMPLE;
      RX_SAMPLE:
        state_nx = RX_WAIT;
      RX_WAIT:
        if (rx_cnt == len || !line_ready) state_nx = PARSE;
        else                              state_nx = RX_SAMPLE;
      PARSE:
        state_nx = (kind_c == RK_NONE) ? SOLVE : TX;
      TX:
        if (resp_next && tx_idx == tot_r) state_nx = SOLVE;
      SOLVE:
        state_nx = WAIT_ACK;
      WAIT_ACK:
        if (solved_ack) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    line_next  = (state == RX_WAIT);
    resp_ready = (state == TX);
    solved     = (state == SOLVE);
    busy       = (state != IDLE);
  end

  // receive counters and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      rx_cnt    <= '0;
      kind_r    <= RK_NONE;
      wlen_r    <= '0;
      tot_r     <= '0;
      tx_idx    <= '0;
      resp_char <= '0;
    end else begin
      case (state)
        IDLE:
          if (line_ready) begin
            len    <= len_in;
            rx_cnt <= '0;
          end
        RX_SAMPLE:
          rx_cnt <= rx_cnt + 13'd1;
        RX_WAIT:
          if (!line_ready) len <= rx_cnt;
        PARSE: begin
          kind_r    <= kind_c;
          wlen_r    <= wlen_c;
          tot_r     <= tot_c;
          tx_idx    <= '0;
          resp_char <= ch_c;
        end
        TX:
          if (resp_next) begin
            if (tx_idx == tot_r) begin
              resp_char <= NUL;
            end else begin
              tx_idx    <= tx_idx + 8'd1;
              resp_char <= ch_c;
            end
          end
        default: ;
      endcase
    end
  end

  // line buffer write, one byte per RX_SAMPLE
  always_ff @(posedge clk) begin
    if (state == RX_SAMPLE)
      line_buf[rx_cnt[AW-1:0]] <= line_char;
  end

endmodule

// File: tb/tb_bash_cmd_dispatcher.sv
// Bench for bash_cmd_dispatcher: console model plus
// scoreboard of expected response bytes.
module tb_bash_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst, line_ready, resp_next, solved_ack;
  logic [12:0] line_len;
  logic [7:0]  line_char;
  logic        line_next, resp_ready, solved, busy;
  logic [7:0]  resp_char;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    string cmd;
    string rsp;
  } vec_t;

  vec_t tbl [$];

  bash_cmd_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .line_ready (line_ready),
    .line_len   (line_len),
    .line_char  (line_char),
    .line_next  (line_next),
    .resp_ready (resp_ready),
    .resp_char  (resp_char),
    .resp_next  (resp_next),
    .solved     (solved),
    .solved_ack (solved_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset(input string tag);
    rst        = 1'b1;
    line_ready = 1'b0;
    resp_next  = 1'b0;
    solved_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk({tag, "_line_next"}, line_next, 0);
    chk({tag, "_resp_ready"}, resp_ready, 0);
    chk({tag, "_resp_char"}, resp_char, 0);
    chk({tag, "_solved"}, solved, 0);
    chk({tag, "_busy"}, busy, 0);
    exp_q.delete();
  endtask

  task automatic run_cmd(input string cmd, input string rsp,
                         input int stall_at, input int abort);
    int n, cyc, idx, nxt, last, term_cyc, solv_cyc, byte_no;
    int stall_left;
    bit done;
    n = cmd.len();
    exp_q.delete();
    if (n > 0) begin
      for (int i = 0; i < rsp.len(); i++) exp_q.push_back(rsp[i]);
      exp_q.push_back(8'h00);
    end
    @(negedge clk);
    line_len   = 13'(n);
    line_char  = (n > 0) ? cmd[0] : 8'h00;
    line_ready = 1'b1;
    cyc = 0; idx = 0; nxt = 0; last = -1;
    term_cyc = -1; solv_cyc = -1; byte_no = 0;
    stall_left = 10; done = 1'b0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (solv_cyc >= 0) begin
        if (cyc == solv_cyc + 1) begin
          chk({cmd, ":solved_one_cycle"}, solved, 0);
          solved_ack = 1'b1;
        end else begin
          solved_ack = 1'b0;
          chk({cmd, ":idle_after_ack"}, busy, 0);
          done = 1'b1;
        end
        continue;
      end
      if (line_next) begin
        nxt++;
        if (last >= 0) chk({cmd, ":line_next_gap"}, cyc - last, 2);
        last = cyc;
        idx++;
        line_char = (idx < n) ? cmd[idx] : 8'h00;
        if (abort == 1 && nxt == 3) begin
          do_reset("rst_rx");
          return;
        end
      end
      if (busy && idx >= n) line_ready = 1'b0;
      if (resp_next) begin
        resp_next = 1'b0;
      end else if (resp_ready) begin
        if (exp_q.size() == 0) begin
          chk({cmd, ":resp_unexpected"}, resp_ready, 0);
        end else if (byte_no == stall_at && stall_left > 0) begin
          chk({cmd, ":stall_hold"}, resp_char, exp_q[0]);
          stall_left--;
        end else begin
          chk($sformatf("%s:resp[%0d]", cmd, byte_no),
              resp_char, exp_q.pop_front());
          byte_no++;
          resp_next = 1'b1;
          if (exp_q.size() == 0) term_cyc = cyc;
          if (abort == 2 && byte_no == 3) begin
            do_reset("rst_tx");
            return;
          end
        end
      end
      if (solved) begin
        solv_cyc = cyc;
        if (n == 0) chk({cmd, ":solved_lat0"}, cyc, 2);
        else        chk({cmd, ":solved_lat"}, cyc, term_cyc + 1);
        chk({cmd, ":resp_ready_off"}, resp_ready, 0);
      end
    end
    if (!done) begin
      n_chk++;
      $display("FAIL %s:timeout after %0d cycles, need completion",
               cmd, cyc);
    end
    chk({cmd, ":line_next_count"}, nxt, n);
    chk({cmd, ":queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst        = 1'b1;
    line_ready = 1'b0;
    line_len   = '0;
    line_char  = '0;
    resp_next  = 1'b0;
    solved_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_line_next", line_next, 0);
    chk("reset_resp_ready", resp_ready, 0);
    chk("reset_resp_char", resp_char, 0);
    chk("reset_solved", solved, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    tbl.push_back('{"echo hi", "hi"});
    tbl.push_back('{"hello", "Hello, FPGA!"});
    tbl.push_back('{"hello!", "hello!: command not found"});
    tbl.push_back('{"", ""});
    tbl.push_back('{"ls -a", "ls: command not found"});
    tbl.push_back('{"echo", ""});
    tbl.push_back('{"echoes", "echoes: command not found"});
    tbl.push_back('{"abcdefghijklmnopqrst",
                    "abcdefghijklmnop: command not found"});
    tbl.push_back('{" x", ": command not found"});
    tbl.push_back('{"echo  a b", " a b"});

    foreach (tbl[i]) run_cmd(tbl[i].cmd, tbl[i].rsp, -1, 0);

    run_cmd("hello", "Hello, FPGA!", 4, 0);
    run_cmd("hello world", "", -1, 1);
    run_cmd("hello", "Hello, FPGA!", -1, 2);
    run_cmd("echo ok", "ok", -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
